// File: rtl/idma_txrx_pkg.sv
// Shared types and helpers for the TXRX RX packer.
// Contents:
//   state_e         packer FSM states (IDLE, FILL, OUT)
//   len_t           transfer length / bytes-left type at the default width
//   datasize_t      valid-byte count type at the default word width
//   datasize_width  width needed to hold a byte count 0..strb (inclusive)
package idma_txrx_pkg;

  localparam int unsigned DefaultStrbWidth = 16;
  localparam int unsigned DefaultLenWidth  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    OUT  = 2'd2
  } state_e;

  typedef logic [DefaultLenWidth-1:0]       len_t;
  typedef logic [$clog2(DefaultStrbWidth):0] datasize_t;

  // A full word holds strb bytes, so the count needs one bit more than log2(strb).
  function automatic int unsigned datasize_width(input int unsigned strb);
    return $clog2(strb) + 1;
  endfunction

endpackage

// File: rtl/idma_txrx_rx_timeout.sv
// Loadable idle counter for the RX packer partial-word flush.
// Only instantiated when IDMA_TXRX_RX_TIMEOUT_EN is defined.
// Ports:
//   clk_i       clock
//   rst_i       synchronous active-high reset
//   count_en_i  count one idle cycle; when low the counter reloads to zero
//   expired_o   high in the idle cycle that completes Cycles idle cycles
module idma_txrx_rx_timeout #(
  parameter int unsigned Cycles = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(Cycles + 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !count_en_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired_o = count_en_i && (count_q == CntW'(Cycles - 1));

endmodule

// File: rtl/idma_txrx_rx_packer.sv
// Packs the narrow RX peripheral byte stream into StrbWidth-byte words and
// presents them as a read response (data/valid/datasize/bytes_left).
// One command is one RX transfer of cmd_len_i bytes.
// Optional feature: define IDMA_TXRX_RX_TIMEOUT_EN to flush a partial word
// after TimeoutCycles idle cycles in FILL.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cmd_len_i/valid_i/ready_o    transfer command
//   periph_data_i/valid_i/ready_o RX beats, byte 0 in bits [7:0]
//   rsp_data_o/valid_o/ready_i   packed word, first byte in lane 0
//   rsp_datasize_o               valid bytes in rsp_data_o
//   rsp_bytes_left_o             bytes of the transfer remaining after this word
//   busy_o                       high in FILL or OUT
module idma_txrx_rx_packer
  import idma_txrx_pkg::*;
#(
  parameter int unsigned StrbWidth     = 16,
  parameter int unsigned PeriphWidth   = 1,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned TimeoutCycles = 64
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [LenWidth-1:0]              cmd_len_i,
  input  logic                             cmd_valid_i,
  output logic                             cmd_ready_o,
  input  logic [8*PeriphWidth-1:0]         periph_data_i,
  input  logic                             periph_valid_i,
  output logic                             periph_ready_o,
  output logic [8*StrbWidth-1:0]           rsp_data_o,
  output logic                             rsp_valid_o,
  input  logic                             rsp_ready_i,
  output logic [$clog2(StrbWidth):0]       rsp_datasize_o,
  output logic [LenWidth-1:0]              rsp_bytes_left_o,
  output logic                             busy_o
);

  localparam int unsigned FillW = datasize_width(StrbWidth);

  state_e                 state_q;
  logic [LenWidth-1:0]    remaining_q, remaining_d;
  logic [FillW-1:0]       fill_q, fill_d, beat_n;
  logic [8*StrbWidth-1:0] word_q, word_d;
  logic                   beat_acc, word_done, timeout_hit;

  assign beat_acc = (state_q == FILL) && periph_valid_i;

  // Bytes taken from this beat; a short last beat only contributes what is left.
  assign beat_n = (remaining_q < LenWidth'(PeriphWidth)) ? FillW'(remaining_q)
                                                         : FillW'(PeriphWidth);
  assign fill_d      = fill_q + beat_n;
  assign remaining_d = remaining_q - LenWidth'(beat_n);
  assign word_done   = (fill_d == FillW'(StrbWidth)) || (remaining_d == '0);

  // fill is always a multiple of PeriphWidth, so lane gi is fed by beat byte
  // gi % PeriphWidth. rel wraps to >= StrbWidth for lanes below fill, which
  // keeps it above any beat_n.
  genvar gi;
  generate
    for (gi = 0; gi < StrbWidth; gi++) begin : g_lane
      logic [FillW-1:0] rel;
      assign rel = FillW'(gi) - fill_q;
      assign word_d[gi*8 +: 8] = (rel < beat_n) ? periph_data_i[(gi % PeriphWidth)*8 +: 8]
                                                : word_q[gi*8 +: 8];
    end
  endgenerate

`ifdef IDMA_TXRX_RX_TIMEOUT_EN
  logic idle_count_en;
  assign idle_count_en = (state_q == FILL) && (fill_q != '0) && !periph_valid_i;

  idma_txrx_rx_timeout #(
    .Cycles(TimeoutCycles)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .count_en_i (idle_count_en),
    .expired_o  (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      fill_q      <= '0;
      word_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            remaining_q <= cmd_len_i;
            fill_q      <= '0;
            word_q      <= '0;
            // A zero-length command is consumed without producing a word.
            if (cmd_len_i != '0) state_q <= FILL;
          end
        end
        FILL: begin
          if (beat_acc) begin
            word_q      <= word_d;
            fill_q      <= fill_d;
            remaining_q <= remaining_d;
            if (word_done) state_q <= OUT;
          end else if (timeout_hit) begin
            state_q <= OUT;
          end
        end
        OUT: begin
          if (rsp_ready_i) begin
            if (remaining_q == '0) begin
              state_q <= IDLE;
            end else begin
              state_q <= FILL;
              fill_q  <= '0;
              word_q  <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o      = (state_q == IDLE);
  assign periph_ready_o   = (state_q == FILL);
  assign rsp_valid_o      = (state_q == OUT);
  assign busy_o           = (state_q != IDLE);
  assign rsp_data_o       = word_q;
  assign rsp_datasize_o   = fill_q;
  assign rsp_bytes_left_o = remaining_q;

endmodule

// File: tb/tb_idma_txrx_rx_packer.sv
module tb_idma_txrx_rx_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: StrbWidth=4, PeriphWidth=1
  logic [31:0] cmd_len;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  pdata;
  logic        pvalid, pready;
  logic [31:0] rdata;
  logic        rvalid, rready;
  logic [2:0]  rsize;
  logic [31:0] rleft;
  logic        busy;

  // dut1: StrbWidth=4, PeriphWidth=2
  logic [31:0] cmd_len_w;
  logic        cmd_valid_w, cmd_ready_w;
  logic [15:0] pdata_w;
  logic        pvalid_w, pready_w;
  logic [31:0] rdata_w;
  logic        rvalid_w, rready_w;
  logic [2:0]  rsize_w;
  logic [31:0] rleft_w;
  logic        busy_w;

  int checks = 0;
  int errors = 0;

  idma_txrx_rx_packer #(.StrbWidth(4), .PeriphWidth(1), .LenWidth(32), .TimeoutCycles(8)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .cmd_len_i(cmd_len), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .periph_data_i(pdata), .periph_valid_i(pvalid), .periph_ready_o(pready),
    .rsp_data_o(rdata), .rsp_valid_o(rvalid), .rsp_ready_i(rready),
    .rsp_datasize_o(rsize), .rsp_bytes_left_o(rleft), .busy_o(busy)
  );

  idma_txrx_rx_packer #(.StrbWidth(4), .PeriphWidth(2), .LenWidth(32), .TimeoutCycles(8)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .cmd_len_i(cmd_len_w), .cmd_valid_i(cmd_valid_w), .cmd_ready_o(cmd_ready_w),
    .periph_data_i(pdata_w), .periph_valid_i(pvalid_w), .periph_ready_o(pready_w),
    .rsp_data_o(rdata_w), .rsp_valid_o(rvalid_w), .rsp_ready_i(rready_w),
    .rsp_datasize_o(rsize_w), .rsp_bytes_left_o(rleft_w), .busy_o(busy_w)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cmd_ready"},  64'(cmd_ready), 64'd1);
    chk({tag, ".periph_rdy"}, 64'(pready),    64'd0);
    chk({tag, ".rsp_valid"},  64'(rvalid),    64'd0);
    chk({tag, ".rsp_data"},   64'(rdata),     64'd0);
    chk({tag, ".datasize"},   64'(rsize),     64'd0);
    chk({tag, ".bytes_left"}, 64'(rleft),     64'd0);
    chk({tag, ".busy"},       64'(busy),      64'd0);
  endtask

  task automatic do_cmd(input logic [31:0] len);
    cmd_len   = len;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) step();
    chk("cmd_ready_wait", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    $display("cmd len=%0d issued", len);
  endtask

  task automatic feed(input logic [7:0] b);
    pdata  = b;
    pvalid = 1'b1;
    for (int i = 0; i < 50 && !pready; i++) step();
    chk("periph_ready_wait", 64'(pready), 64'd1);
    step();
    pvalid = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic [2:0] s,
                             input logic [31:0] l);
    for (int i = 0; i < 50 && !rvalid; i++) step();
    chk({tag, ".valid"}, 64'(rvalid), 64'd1);
    chk({tag, ".data"},  64'(rdata),  64'(d));
    chk({tag, ".size"},  64'(rsize),  64'(s));
    chk({tag, ".left"},  64'(rleft),  64'(l));
    $display("word %s data=%08h size=%0d left=%0d", tag, rdata, rsize, rleft);
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_len = '0; cmd_valid = 1'b0; pdata = '0; pvalid = 1'b0; rready = 1'b0;
    cmd_len_w = '0; cmd_valid_w = 1'b0; pdata_w = '0; pvalid_w = 1'b0; rready_w = 1'b0;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // len=8, two full words
    do_cmd(32'd8);
    for (int i = 0; i < 4; i++) feed(8'(i));
    expect_word("l8w0", 32'h03020100, 3'd4, 32'd4);
    for (int i = 4; i < 8; i++) feed(8'(i));
    expect_word("l8w1", 32'h07060504, 3'd4, 32'd0);
    chk("l8.idle_busy", 64'(busy), 64'd0);

    // len=6, full word then partial word
    do_cmd(32'd6);
    for (int i = 0; i < 4; i++) feed(8'(i));
    expect_word("l6w0", 32'h03020100, 3'd4, 32'd2);
    feed(8'h04);
    feed(8'h05);
    expect_word("l6w1", 32'h00000504, 3'd2, 32'd0);
    chk("l6.idle_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("l6.idle_busy",      64'(busy),      64'd0);

    // len=4 with backpressure: word held stable, no RX beats accepted
    do_cmd(32'd4);
    for (int i = 0; i < 4; i++) feed(8'h10 + 8'(i));
    pvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid",  64'(rvalid), 64'd1);
      chk("bp.data",   64'(rdata),  64'h13121110);
      chk("bp.pready", 64'(pready), 64'd0);
      step();
    end
    pvalid = 1'b0;
    expect_word("bp", 32'h13121110, 3'd4, 32'd0);

    // len=0: consumed in one cycle, no word
    cmd_len   = 32'd0;
    cmd_valid = 1'b1;
    chk("l0.cmd_ready", 64'(cmd_ready), 64'd1);
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("l0.rsp_valid", 64'(rvalid), 64'd0);
      chk("l0.busy",      64'(busy),   64'd0);
      step();
    end
    $display("cmd len=0 consumed");

    // Reset mid-transfer, then a clean word
    do_cmd(32'd8);
    feed(8'h55);
    feed(8'h66);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    do_cmd(32'd4);
    feed(8'hAA); feed(8'hBB); feed(8'hCC); feed(8'hDD);
    expect_word("postrst", 32'hDDCCBBAA, 3'd4, 32'd0);

    // PeriphWidth=2, len=3: second beat upper byte dropped
    cmd_len_w   = 32'd3;
    cmd_valid_w = 1'b1;
    chk("w2.cmd_ready", 64'(cmd_ready_w), 64'd1);
    step();
    cmd_valid_w = 1'b0;
    pvalid_w = 1'b1;
    pdata_w  = 16'h0100;
    chk("w2.pready", 64'(pready_w), 64'd1);
    step();
    pdata_w = 16'h0302;
    step();
    pvalid_w = 1'b0;
    for (int i = 0; i < 50 && !rvalid_w; i++) step();
    chk("w2.valid", 64'(rvalid_w), 64'd1);
    chk("w2.data",  64'(rdata_w),  64'h00020100);
    chk("w2.size",  64'(rsize_w),  64'd3);
    chk("w2.left",  64'(rleft_w),  64'd0);
    $display("word w2 data=%08h size=%0d left=%0d", rdata_w, rsize_w, rleft_w);
    rready_w = 1'b1;
    step();
    rready_w = 1'b0;
    chk("w2.busy", 64'(busy_w), 64'd0);

`ifdef IDMA_TXRX_RX_TIMEOUT_EN
    // Partial-word flush after 8 idle cycles
    begin
      int wait_cycles;
      do_cmd(32'd8);
      feed(8'h00); feed(8'h01); feed(8'h02);
      wait_cycles = 0;
      while (!rvalid && wait_cycles < 50) begin
        step();
        wait_cycles++;
      end
      chk("to.latency", 64'(wait_cycles), 64'd8);
      expect_word("to0", 32'h00020100, 3'd3, 32'd5);
      for (int i = 3; i < 7; i++) feed(8'(i));
      expect_word("to1", 32'h06050403, 3'd4, 32'd1);
      feed(8'h07);
      expect_word("to2", 32'h00000007, 3'd1, 32'd0);
    end
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
